// File: rtl/apb_mp_pkg.sv
// Shared types for the multi-slave APB master: FSM states, response status codes
// and a constant-width helper.
package apb_mp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    ERR    = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [1:0] OKAY    = 2'd0;
  localparam logic [1:0] SLVERR  = 2'd1;
  localparam logic [1:0] DECERR  = 2'd2;
  localparam logic [1:0] TIMEOUT = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/apb_mp_decoder.sv
// Combinational slave decode from the top SEL_BITS of the address: one-hot select,
// raw index and a flag for indices with no slave behind them.
module apb_mp_decoder #(
  parameter int ADDR_WIDTH = 9,
  parameter int SEL_BITS   = 1,
  parameter int NUM_SLAVES = 2
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_SLAVES-1:0] psel_o,
  output logic [SEL_BITS-1:0]   idx_o,
  output logic                  dec_err_o
);

  // Only the select field matters here; the offset bits go to PADDR elsewhere.
  logic unused_offset;
  assign unused_offset = ^addr_i[ADDR_WIDTH-SEL_BITS-1:0];

  assign idx_o     = addr_i[ADDR_WIDTH-1 -: SEL_BITS];
  assign dec_err_o = (int'(idx_o) >= NUM_SLAVES);

  always_comb begin
    psel_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      psel_o[i] = (int'(idx_o) == i);
    end
  end

endmodule

// File: rtl/apb_master_mp.sv
// APB4 master for NUM_SLAVES slaves: one command at a time, IDLE->SETUP->ACCESS->RESP,
// 3-cycle latency plus wait states, no response backpressure, optional wait-state watchdog.
module apb_master_mp
  import apb_mp_pkg::*;
#(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_SLAVES     = 2,
  parameter int SEL_BITS       = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRST,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_status,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int WD_RAW = clog2(TIMEOUT_CYCLES + 1);
  localparam int WD_W   = (WD_RAW < 1) ? 1 : WD_RAW;

  state_t                    state_q;
  logic [SEL_BITS-1:0]       idx_q;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic                      cmd_ready_q, rsp_valid_q, penable_q, pwrite_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, pwdata_q;
  logic [1:0]                rsp_status_q;
  logic [ADDR_WIDTH-1:0]     paddr_q;
  logic [NUM_SLAVES-1:0]     psel_q;
  logic [DATA_WIDTH/8-1:0]   pstrb_q;

  logic [NUM_SLAVES-1:0]     dec_psel;
  logic [SEL_BITS-1:0]       dec_idx;
  logic                      dec_err;
  logic                      sel_ready, sel_err, timeout_hit;
  logic [DATA_WIDTH-1:0]     sel_rdata;

  apb_mp_decoder #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .SEL_BITS  (SEL_BITS),
    .NUM_SLAVES(NUM_SLAVES)
  ) u_dec (
    .addr_i   (cmd_addr),
    .psel_o   (dec_psel),
    .idx_o    (dec_idx),
    .dec_err_o(dec_err)
  );

  always_comb begin
    sel_ready   = PREADY[idx_q];
    sel_err     = PSLVERR[idx_q];
    sel_rdata   = PRDATA[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    wd_d        = (wd_q == '1) ? wd_q : wd_q + 1'b1;
    // This ACCESS cycle is the TIMEOUT_CYCLES-th one with PREADY low.
    timeout_hit = (TIMEOUT_CYCLES != 0) && ((int'(wd_q) + 1) >= TIMEOUT_CYCLES);
  end

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wd_q         <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= OKAY;
      paddr_q      <= '0;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_wdata;
            pwrite_q    <= cmd_write;
            pstrb_q     <= cmd_write ? cmd_strb : '0;
            idx_q       <= dec_idx;
            wd_q        <= '0;
            cmd_ready_q <= 1'b0;
            if (dec_err) begin
              state_q <= ERR;
            end else begin
              psel_q  <= dec_psel;
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            psel_q       <= '0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= sel_err ? SLVERR : OKAY;
            rsp_rdata_q  <= (!pwrite_q && !sel_err) ? sel_rdata : '0;
            state_q      <= RESP;
          end else if (timeout_hit) begin
            psel_q       <= '0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= TIMEOUT;
            rsp_rdata_q  <= '0;
            state_q      <= RESP;
          end else begin
            wd_q <= wd_d;
          end
        end
        ERR: begin
          rsp_valid_q  <= 1'b1;
          rsp_status_q <= DECERR;
          rsp_rdata_q  <= '0;
          state_q      <= RESP;
        end
        RESP: begin
          rsp_valid_q  <= 1'b0;
          rsp_status_q <= OKAY;
          rsp_rdata_q  <= '0;
          cmd_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          psel_q      <= '0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;
  assign PADDR      = paddr_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;

endmodule

// File: tb/tb_apb_master_mp.sv
// Directed bench: three slaves, 2 select bits, watchdog of 4 ACCESS cycles.
// Slave i sits at addr[8:7]==i; index 3 has no slave.
module tb_apb_master_mp;

  logic        PCLK = 1'b0;
  logic        PRST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [8:0]  cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [0:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_status;
  logic [8:0]  PADDR;
  logic [2:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PWDATA;
  logic [0:0]  PSTRB;
  logic [23:0] PRDATA = {8'h55, 8'h77, 8'h3C};
  logic [2:0]  PREADY = '0;
  logic [2:0]  PSLVERR = '0;

  int total = 0;
  int bad   = 0;

  // Slave behaviour knobs
  int   wait_n = 0;
  int   acc_cnt = 0;
  logic hang = 1'b0;
  logic late_pulse = 1'b0;

  // Results captured by run_cmd
  int         lat, n_en, extra;
  logic [1:0] st;
  logic [7:0] rd;
  logic [2:0] psel1;
  logic [0:0] pstrb1;
  logic [7:0] pwdata1;
  logic       pwrite1;
  logic [8:0] paddr1;
  logic [3:0] rsp_bus;
  logic       rdy_after;

  apb_master_mp #(
    .ADDR_WIDTH    (9),
    .DATA_WIDTH    (8),
    .NUM_SLAVES    (3),
    .SEL_BITS      (2),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK      (PCLK),
    .PRST      (PRST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_status(rsp_status),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Slave model: PREADY low for wait_n ACCESS cycles, or forever when hang is set.
  always @(negedge PCLK) begin
    if (PENABLE && (PSEL != 3'b000)) begin
      PREADY  = (!hang && acc_cnt >= wait_n) ? 3'b111 : 3'b000;
      acc_cnt = acc_cnt + 1;
    end else begin
      PREADY  = late_pulse ? 3'b111 : 3'b000;
      acc_cnt = 0;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one command, then follow it cycle by cycle until rsp_valid (bounded).
  task automatic run_cmd(input logic wr, input logic [8:0] a, input logic [7:0] wd,
                         input logic [0:0] sb);
    @(negedge PCLK);
    chk_eq("rdy_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_strb = sb;
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0; cmd_addr = 9'h1FF; cmd_wdata = 8'hEE; cmd_write = ~wr;
    lat = -1; n_en = 0; st = 2'bxx; rd = 8'hxx; rsp_bus = 4'hx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge PCLK);
      if (PENABLE) n_en = n_en + 1;
      if (k == 1) begin
        psel1 = PSEL; pstrb1 = PSTRB; pwdata1 = PWDATA; pwrite1 = PWRITE; paddr1 = PADDR;
      end
      if (rsp_valid) begin
        lat = k; st = rsp_status; rd = rsp_rdata; rsp_bus = {PSEL, PENABLE};
        break;
      end
    end
    if (lat < 0) $display("FAIL rsp_timeout no rsp_valid within 40 cycles");
    @(negedge PCLK);
    rdy_after = cmd_ready;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk_eq("rst_cmd_ready", cmd_ready, 1);
    chk_eq("rst_outs", {rsp_valid, PSEL, PENABLE, PWRITE, PSTRB}, 0);
    chk_eq("rst_data", {PADDR, PWDATA, rsp_rdata, rsp_status}, 0);
    PRST = 1'b0;

    // Write to slave 1, zero wait states
    wait_n = 0;
    run_cmd(1'b1, 9'h0A5, 8'hA5, 1'b1);
    chk_eq("wr_lat", lat, 3);
    chk_eq("wr_status", st, 0);
    chk_eq("wr_rdata", rd, 0);
    chk_eq("wr_psel", psel1, 3'b010);
    chk_eq("wr_pstrb", pstrb1, 1);
    chk_eq("wr_pwdata", pwdata1, 8'hA5);
    chk_eq("wr_pwrite", pwrite1, 1);
    chk_eq("wr_paddr", paddr1, 9'h0A5);
    chk_eq("wr_n_en", n_en, 1);
    chk_eq("wr_bus_at_rsp", rsp_bus, 0);
    chk_eq("wr_rdy_after", rdy_after, 1);

    // Read slave 0 with 3 wait states; strobe must be masked
    wait_n = 3;
    run_cmd(1'b0, 9'h012, 8'h00, 1'b1);
    chk_eq("rd_lat", lat, 6);
    chk_eq("rd_rdata", rd, 8'h3C);
    chk_eq("rd_status", st, 0);
    chk_eq("rd_n_en", n_en, 4);
    chk_eq("rd_pstrb", pstrb1, 0);
    chk_eq("rd_psel", psel1, 3'b001);
    chk_eq("rd_pwrite", pwrite1, 0);
    wait_n = 0;

    // Read slave 2 picks the top PRDATA slice
    run_cmd(1'b0, 9'h150, 8'h00, 1'b0);
    chk_eq("rd2_psel", psel1, 3'b100);
    chk_eq("rd2_rdata", rd, 8'h55);
    chk_eq("rd2_lat", lat, 3);

    // Slave error on read
    PSLVERR = 3'b001;
    run_cmd(1'b0, 9'h012, 8'h00, 1'b0);
    chk_eq("slverr_status", st, 1);
    chk_eq("slverr_rdata", rd, 0);
    PSLVERR = 3'b000;

    // Decode error: index 3 has no slave
    run_cmd(1'b1, 9'h1A0, 8'h11, 1'b1);
    chk_eq("dec_lat", lat, 2);
    chk_eq("dec_status", st, 2);
    chk_eq("dec_psel", psel1, 0);
    chk_eq("dec_n_en", n_en, 0);
    chk_eq("dec_rdata", rd, 0);

    // Timeout, then PREADY high after the response must not yield another
    hang = 1'b1; late_pulse = 1'b1;
    run_cmd(1'b0, 9'h0A5, 8'h00, 1'b0);
    chk_eq("to_lat", lat, 6);
    chk_eq("to_status", st, 3);
    chk_eq("to_n_en", n_en, 4);
    chk_eq("to_bus_at_rsp", rsp_bus, 0);
    chk_eq("to_rdata", rd, 0);
    extra = 0;
    repeat (5) begin
      @(negedge PCLK);
      if (rsp_valid) extra = extra + 1;
    end
    chk_eq("to_no_second_rsp", extra, 0);
    late_pulse = 1'b0;

    // Reset during wait states
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h012; cmd_wdata = 8'hC3; cmd_strb = 1'b1;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge PCLK);
    chk_eq("mid_penable", PENABLE, 1);
    PRST = 1'b1;
    @(negedge PCLK);
    PRST = 1'b0;
    chk_eq("mid_rst_outs", {rsp_valid, PSEL, PENABLE, PWRITE, PSTRB}, 0);
    chk_eq("mid_rst_paddr", PADDR, 0);
    chk_eq("mid_rst_ready", cmd_ready, 1);
    hang = 1'b0;
    extra = 0;
    repeat (3) begin
      @(negedge PCLK);
      if (rsp_valid) extra = extra + 1;
    end
    chk_eq("mid_no_rsp", extra, 0);
    run_cmd(1'b1, 9'h033, 8'h5A, 1'b1);
    chk_eq("post_rst_status", st, 0);
    chk_eq("post_rst_lat", lat, 3);
    chk_eq("post_rst_psel", psel1, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_mp.md
Name: apb_master_mp

Overview:
- Parametrised APB4 master, successor to the single-pair APB master.
- Accepts one command at a time on a valid/ready request port and runs a full IDLE→SETUP→ACCESS transfer to one of NUM_SLAVES slaves, selected by the upper address bits.
- Returns a one-cycle response pulse carrying read data and a 2-bit status: OKAY, SLVERR, DECERR or TIMEOUT.
- Adds PSTRB, per-slave PREADY/PSLVERR muxing, address-decode errors and a wait-state watchdog.

Parameters:
- ADDR_WIDTH, 9: PADDR/cmd_addr width.
- DATA_WIDTH, 8: PWDATA/PRDATA width; must be a multiple of 8.
- NUM_SLAVES, 2: number of PSEL lines; 1..2^SEL_BITS.
- SEL_BITS, 1: number of top address bits used for slave decode; must be less than ADDR_WIDTH.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles with PREADY low; 0 disables the watchdog.

Ports:
- PCLK  in  1  clock; all logic rises on the posedge.
- PRST  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; handshake = cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for error responses.
- rsp_status  out  2  00 OKAY, 01 SLVERR, 10 DECERR, 11 TIMEOUT.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  DATA_WIDTH/8  byte strobes; 0 on reads.
- PRDATA  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- PREADY  in  NUM_SLAVES  per-slave ready.
- PSLVERR  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset (PRST high at a posedge):
  - state=IDLE; every output 0 except cmd_ready=1 after the reset edge.
  - Any in-flight transfer is aborted with no rsp_valid; the watchdog counter is cleared.
- State machine, registered:
  - IDLE: on handshake, latch addr, wdata, strb and write into PADDR/PWDATA/PSTRB/PWRITE.
    - idx = cmd_addr[ADDR_WIDTH-1 -: SEL_BITS].
    - idx < NUM_SLAVES → SETUP.
    - Otherwise → ERR, with no PSEL asserted.
  - SETUP (exactly 1 cycle): PSEL[idx]=1, PENABLE=0 → ACCESS.
  - ACCESS: PSEL[idx]=1, PENABLE=1, with PADDR/PWDATA/PWRITE/PSTRB held stable.
    - When PREADY[idx]=1 at a posedge: capture PRDATA slice idx if read; status = PSLVERR[idx] ? SLVERR : OKAY → RESP.
    - When PREADY[idx]=0: the watchdog increments.
    - If the watchdog reaches TIMEOUT_CYCLES (nonzero) before PREADY → RESP with TIMEOUT.
  - ERR: → RESP with DECERR.
  - RESP (1 cycle): rsp_valid=1, PSEL=0, PENABLE=0 → IDLE.
- Latency, read or write with zero wait states: accept at edge N, SETUP visible in cycle N+1, ACCESS in cycle N+2, rsp_valid in cycle N+3, cmd_ready high again in cycle N+4. Each PREADY-low cycle adds 1.
- Throughput: the next command is accepted no earlier than one cycle after rsp_valid.
- Timeout: after TIMEOUT_CYCLES consecutive ACCESS cycles with PREADY low, the transfer is abandoned. PSEL/PENABLE drop in the RESP cycle, and a late PREADY is ignored.
- Errors and PSTRB:
  - rsp_rdata=0 whenever status≠OKAY or the transfer is a write.
  - PSLVERR is sampled only in the ACCESS cycle where PREADY is high.
  - PSTRB is forced to 0 for reads regardless of cmd_strb.
- Flow control: commands are ignored while cmd_ready=0; cmd inputs may change freely outside the handshake cycle.
- Width rules:
  - The watchdog counter is clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.
  - The PRDATA slice select is idx*DATA_WIDTH.
  - Non-selected slaves' PREADY/PSLVERR/PRDATA are don't-care.

Decomposition:
- Package apb_mp_pkg holds:
  - state encodings: IDLE, SETUP, ACCESS, ERR, RESP;
  - status codes: OKAY=0, SLVERR=1, DECERR=2, TIMEOUT=3;
  - a clog2 function.
- One sub-module, apb_mp_decoder: combinational addr → one-hot PSEL plus a decode-error flag, parametrised by ADDR_WIDTH, SEL_BITS and NUM_SLAVES.
- The FSM, watchdog and datapath stay in apb_master_mp.

Test Plan:
- Write to slave 1, zero wait states: addr=0x105, wdata=0xA5, strb=1, PREADY=2'b11 → PSEL=2'b10 for 2 cycles, PSTRB=1, PWDATA=0xA5, rsp_valid at N+3, status=00, rdata=0.
- Read from slave 0 with 3 wait states: addr=0x012, PRDATA[7:0]=0x3C, PREADY[0] low for 3 ACCESS cycles → PENABLE high for 4 cycles, PSTRB=0, rsp at N+6, rdata=0x3C, status=00.
- Slave error: read with PSLVERR[0]=1 in the ready cycle → status=01, rdata=0.
- Decode error: NUM_SLAVES=3, SEL_BITS=2, addr top bits=2'b11 → PSEL stays 0, rsp_valid at N+2, status=10.
- Timeout: TIMEOUT_CYCLES=4, PREADY held low → exactly 4 ACCESS cycles, status=11, PSEL=0 in the response cycle; a PREADY pulse one cycle later produces no second response.
- Reset mid-ACCESS: PRST=1 for 1 cycle during wait states → all outputs 0 next cycle, no rsp_valid, cmd_ready=1; a following write completes with status=00.
